// File: rtl/score4_board_ctrl.sv
// rtl/score4_board_ctrl.sv - Score 4 game-state stage feeding find_winner
// Applies gravity to column drops, holds panel/turn for find_winner and samples its verdict.
module score4_board_ctrl #(
   parameter logic FIRST_PLAYER = 1'b0,
   parameter int   MAX_PIECES   = 42
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  new_game,
   input  logic                  move_valid,
   input  logic [2:0]            move_col,
   output logic                  move_ready,
   output logic                  move_err,
   output logic [6:0][5:0][1:0]  panel,
   output logic                  turn,
   input  logic                  win_exists,
   input  logic                  win_player,
   output logic                  game_over,
   output logic                  draw,
   output logic                  winner,
   output logic [5:0]            piece_cnt
);

   typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

   state_t     state;
   logic [2:0] height [0:6];
   logic       col_ok;
   logic [2:0] col_idx;
   logic [2:0] col_h;
   logic       legal;

   // Column 7 is steered to a safe index; legal is what keeps it off the board.
   always_comb begin
      col_ok  = (move_col != 3'd7);
      col_idx = col_ok ? move_col : 3'd0;
      col_h   = height[col_idx];
      legal   = col_ok && (col_h < 3'd6);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         panel      <= '0;
         for (int i = 0; i < 7; i++) height[i] <= 3'd0;
         piece_cnt  <= 6'd0;
         turn       <= FIRST_PLAYER;
         move_ready <= 1'b1;
         move_err   <= 1'b0;
         game_over  <= 1'b0;
         draw       <= 1'b0;
         winner     <= 1'b0;
      end else if (new_game) begin
         state      <= IDLE;
         panel      <= '0;
         for (int i = 0; i < 7; i++) height[i] <= 3'd0;
         piece_cnt  <= 6'd0;
         turn       <= FIRST_PLAYER;
         move_ready <= 1'b1;
         move_err   <= 1'b0;
         game_over  <= 1'b0;
         draw       <= 1'b0;
         winner     <= 1'b0;
      end else begin
         move_err <= 1'b0;
         case (state)
            IDLE: begin
               if (move_valid && move_ready) begin
                  if (legal) begin
                     panel[move_col][col_h] <= turn ? 2'b10 : 2'b01;
                     height[move_col]       <= col_h + 3'd1;
                     if (piece_cnt < 6'(MAX_PIECES)) piece_cnt <= piece_cnt + 6'd1;
                     turn       <= ~turn;
                     move_ready <= 1'b0;
                     state      <= CHECK;
                  end else begin
                     move_err <= 1'b1;
                  end
               end
            end
            CHECK: begin
               // find_winner is looking at the new panel with the toggled turn here.
               if (win_exists) begin
                  winner    <= win_player;
                  game_over <= 1'b1;
                  state     <= OVER;
               end else if (piece_cnt == 6'(MAX_PIECES)) begin
                  draw      <= 1'b1;
                  game_over <= 1'b1;
                  state     <= OVER;
               end else begin
                  move_ready <= 1'b1;
                  state      <= IDLE;
               end
            end
            OVER: begin
               move_ready <= 1'b0;
            end
            default: begin
               move_ready <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score4_board_ctrl.sv
// tb/tb_score4_board_ctrl.sv - directed bench for score4_board_ctrl
// A four-in-a-row model stands in for find_winner; force_win emulates a reported win.
module tb_score4_board_ctrl;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 new_game = 1'b0;
   logic                 move_valid = 1'b0;
   logic [2:0]           move_col = 3'd0;
   logic                 move_ready, move_err, turn, game_over, draw, winner;
   logic [6:0][5:0][1:0] panel;
   logic [5:0]           piece_cnt;
   logic                 win_exists, win_player;
   logic                 force_win = 1'b0;
   logic [1:0]           model;
   int                   errors = 0;
   int                   checks = 0;
   int                   seq [42];

   always #5 clk = ~clk;

   score4_board_ctrl dut (
      .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid), .move_col(move_col),
      .move_ready(move_ready), .move_err(move_err), .panel(panel), .turn(turn),
      .win_exists(win_exists), .win_player(win_player), .game_over(game_over), .draw(draw),
      .winner(winner), .piece_cnt(piece_cnt)
   );

   function automatic logic [1:0] fw(input logic [6:0][5:0][1:0] p);
      logic [1:0] res;
      logic [1:0] v;
      int dc, dr, ec, er;
      res = 2'b00;
      for (int c = 0; c < 7; c++)
         for (int r = 0; r < 6; r++)
            for (int d = 0; d < 4; d++) begin
               dc = (d == 1) ? 0 : 1;
               dr = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
               ec = c + 3 * dc;
               er = r + 3 * dr;
               v  = p[c][r];
               if (v != 2'b00 && ec < 7 && er >= 0 && er < 6 && p[c+dc][r+dr] == v &&
                   p[c+2*dc][r+2*dr] == v && p[ec][er] == v)
                  res = {1'b1, v[1]};
            end
      return res;
   endfunction

   always_comb begin
      model      = fw(panel);
      win_exists = model[1] | force_win;
      win_player = force_win ? ~turn : model[0];
   end

   task automatic drive_move(input logic [2:0] c);
      @(negedge clk);
      move_valid = 1'b1;
      move_col   = c;
      @(negedge clk);
      move_valid = 1'b0;
   endtask

   task automatic play_move(input logic [2:0] c);
      drive_move(c);
      @(negedge clk);
   endtask

   task automatic do_new_game();
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (panel !== '0) begin $display("FAIL reset_panel got=%0h exp=0", panel); errors++; end
      checks++; if (turn !== 1'b0) begin $display("FAIL reset_turn got=%b exp=0", turn); errors++; end
      checks++; if (move_ready !== 1'b1) begin $display("FAIL reset_ready got=%b exp=1", move_ready); errors++; end
      checks++; if ({game_over, draw, winner, move_err} !== 4'b0) begin
         $display("FAIL reset_flags got=%b exp=0000", {game_over, draw, winner, move_err}); errors++; end
      checks++; if (piece_cnt !== 6'd0) begin $display("FAIL reset_cnt got=%0d exp=0", piece_cnt); errors++; end
   endtask

   task automatic test_gravity();
      do_new_game();
      play_move(3'd3);
      play_move(3'd3);
      play_move(3'd3);
      checks++; if (panel[3][0] !== 2'b01) begin $display("FAIL grav_r0 got=%b exp=01", panel[3][0]); errors++; end
      checks++; if (panel[3][1] !== 2'b10) begin $display("FAIL grav_r1 got=%b exp=10", panel[3][1]); errors++; end
      checks++; if (panel[3][2] !== 2'b01) begin $display("FAIL grav_r2 got=%b exp=01", panel[3][2]); errors++; end
      checks++; if (panel[3][3] !== 2'b00) begin $display("FAIL grav_r3 got=%b exp=00", panel[3][3]); errors++; end
      checks++; if (turn !== 1'b1) begin $display("FAIL grav_turn got=%b exp=1", turn); errors++; end
      checks++; if (piece_cnt !== 6'd3) begin $display("FAIL grav_cnt got=%0d exp=3", piece_cnt); errors++; end
   endtask

   task automatic test_vertical_win();
      do_new_game();
      for (int i = 0; i < 7; i++) play_move((i % 2 == 0) ? 3'd0 : 3'd1);
      checks++; if (game_over !== 1'b1) begin $display("FAIL vwin_over got=%b exp=1", game_over); errors++; end
      checks++; if (winner !== 1'b0) begin $display("FAIL vwin_winner got=%b exp=0", winner); errors++; end
      checks++; if (draw !== 1'b0) begin $display("FAIL vwin_draw got=%b exp=0", draw); errors++; end
      checks++; if (move_ready !== 1'b0) begin $display("FAIL vwin_ready got=%b exp=0", move_ready); errors++; end
      drive_move(3'd3);
      checks++; if (move_err !== 1'b0) begin $display("FAIL over_err got=%b exp=0", move_err); errors++; end
      @(negedge clk);
      checks++; if (piece_cnt !== 6'd7) begin $display("FAIL over_cnt got=%0d exp=7", piece_cnt); errors++; end
      checks++; if (panel[3][0] !== 2'b00) begin $display("FAIL over_panel got=%b exp=00", panel[3][0]); errors++; end
   endtask

   task automatic test_illegal();
      do_new_game();
      for (int i = 0; i < 6; i++) play_move(3'd2);
      drive_move(3'd2);
      checks++; if (move_err !== 1'b1) begin $display("FAIL full_err got=%b exp=1", move_err); errors++; end
      @(negedge clk);
      checks++; if (move_err !== 1'b0) begin $display("FAIL full_err_pulse got=%b exp=0", move_err); errors++; end
      checks++; if (turn !== 1'b0) begin $display("FAIL full_turn got=%b exp=0", turn); errors++; end
      checks++; if (piece_cnt !== 6'd6) begin $display("FAIL full_cnt got=%0d exp=6", piece_cnt); errors++; end
      checks++; if (panel[2][5] !== 2'b10 || panel[2][0] !== 2'b01) begin
         $display("FAIL full_panel got=%b/%b exp=10/01", panel[2][5], panel[2][0]); errors++; end
      drive_move(3'd2);
      checks++; if (move_err !== 1'b1) begin $display("FAIL full_again_err got=%b exp=1", move_err); errors++; end
      drive_move(3'd7);
      checks++; if (move_err !== 1'b1) begin $display("FAIL col7_err got=%b exp=1", move_err); errors++; end
      @(negedge clk);
      checks++; if (piece_cnt !== 6'd6 || move_ready !== 1'b1) begin
         $display("FAIL col7_state got cnt=%0d rdy=%b exp cnt=6 rdy=1", piece_cnt, move_ready); errors++; end
      play_move(3'd5);
      checks++; if (panel[5][0] !== 2'b01 || piece_cnt !== 6'd7) begin
         $display("FAIL after_err got=%b cnt=%0d exp=01 cnt=7", panel[5][0], piece_cnt); errors++; end
   endtask

   task automatic build_seq();
      int k;
      int pa [3];
      int pb [3];
      pa = '{0, 1, 4};
      pb = '{2, 3, 6};
      k = 0;
      for (int p = 0; p < 3; p++)
         for (int j = 0; j < 3; j++) begin
            seq[k] = pa[p]; seq[k+1] = pb[p]; seq[k+2] = pb[p]; seq[k+3] = pa[p];
            k += 4;
         end
      for (int j = 0; j < 6; j++) seq[36+j] = 5;
   endtask

   task automatic test_draw();
      build_seq();
      do_new_game();
      for (int i = 0; i < 41; i++) play_move(3'(seq[i]));
      checks++; if (game_over !== 1'b0 || piece_cnt !== 6'd41) begin
         $display("FAIL draw_41 got over=%b cnt=%0d exp over=0 cnt=41", game_over, piece_cnt); errors++; end
      play_move(3'(seq[41]));
      checks++; if (draw !== 1'b1 || game_over !== 1'b1) begin
         $display("FAIL draw_flags got draw=%b over=%b exp 1/1", draw, game_over); errors++; end
      checks++; if (piece_cnt !== 6'd42) begin $display("FAIL draw_cnt got=%0d exp=42", piece_cnt); errors++; end
      checks++; if (panel[5][5] !== 2'b10 || panel[2][0] !== 2'b10 || panel[0][0] !== 2'b01) begin
         $display("FAIL draw_panel got=%b/%b/%b exp=10/10/01", panel[5][5], panel[2][0], panel[0][0]); errors++; end
      do_new_game();
      for (int i = 0; i < 41; i++) play_move(3'(seq[i]));
      force_win = 1'b1;
      play_move(3'(seq[41]));
      force_win = 1'b0;
      checks++; if (draw !== 1'b0 || game_over !== 1'b1 || winner !== 1'b1) begin
         $display("FAIL win42 got draw=%b over=%b win=%b exp 0/1/1", draw, game_over, winner); errors++; end
   endtask

   task automatic test_back_to_back();
      do_new_game();
      @(negedge clk);
      move_valid = 1'b1;
      move_col   = 3'd4;
      repeat (4) @(negedge clk);
      move_valid = 1'b0;
      checks++; if (piece_cnt !== 6'd2 || panel[4][0] !== 2'b01 || panel[4][1] !== 2'b10) begin
         $display("FAIL b2b got cnt=%0d r0=%b r1=%b exp cnt=2 01 10", piece_cnt, panel[4][0], panel[4][1]); errors++; end
   endtask

   task automatic test_new_game();
      for (int i = 0; i < 7; i++) play_move((i % 2 == 0) ? 3'd0 : 3'd1);
      do_new_game();
      checks++; if (game_over !== 1'b0 || panel !== '0 || move_ready !== 1'b1 || piece_cnt !== 6'd0) begin
         $display("FAIL ng_over got over=%b rdy=%b cnt=%0d exp 0/1/0", game_over, move_ready, piece_cnt); errors++; end
      drive_move(3'd0);
      new_game  = 1'b1;
      force_win = 1'b1;
      @(negedge clk);
      new_game  = 1'b0;
      force_win = 1'b0;
      checks++; if (game_over !== 1'b0 || winner !== 1'b0 || panel !== '0 || turn !== 1'b0 || move_ready !== 1'b1) begin
         $display("FAIL ng_check got over=%b win=%b turn=%b rdy=%b exp 0/0/0/1", game_over, winner, turn, move_ready); errors++; end
      @(negedge clk);
      move_valid = 1'b1;
      move_col   = 3'd6;
      new_game   = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
      new_game   = 1'b0;
      checks++; if (piece_cnt !== 6'd0 || move_err !== 1'b0 || panel !== '0) begin
         $display("FAIL ng_hs got cnt=%0d err=%b exp cnt=0 err=0", piece_cnt, move_err); errors++; end
      drive_move(3'd1);
      force_win = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      checks++; if (panel !== '0 || piece_cnt !== 6'd0 || move_ready !== 1'b1 || turn !== 1'b0) begin
         $display("FAIL rst_async got cnt=%0d rdy=%b turn=%b exp 0/1/0", piece_cnt, move_ready, turn); errors++; end
      #1;
      rst       = 1'b0;
      force_win = 1'b0;
      @(negedge clk);
      checks++; if (game_over !== 1'b0 || winner !== 1'b0 || move_ready !== 1'b1) begin
         $display("FAIL rst_verdict got over=%b win=%b rdy=%b exp 0/0/1", game_over, winner, move_ready); errors++; end
   endtask

   initial begin
      test_reset();
      test_gravity();
      test_vertical_win();
      test_illegal();
      test_draw();
      test_back_to_back();
      test_new_game();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
